// File: rtl/rr_switch_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_switch_arbiter                                                        |
// | Round-robin arbitration of memory write port, free-list and learn table  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_switch_arbiter #(
  parameter  int NUM_PORTS  = 4,
  parameter  int ADDR_W     = 12,
  parameter  int BLOCK_BITS = 64,
  parameter  int MAX_BURST  = 1,
  localparam int PW         = $clog2(NUM_PORTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // memory write port
  input  logic                  wr_req_i             [NUM_PORTS-1:0],
  input  logic [ADDR_W-1:0]     wr_addr_i            [NUM_PORTS-1:0],
  input  logic [BLOCK_BITS-1:0] wr_data_i            [NUM_PORTS-1:0],
  output logic                  wr_gnt_o             [NUM_PORTS-1:0],
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [BLOCK_BITS-1:0] mem_wdata_o,
  // free-list allocation
  input  logic                  fl_req_i             [NUM_PORTS-1:0],
  output logic                  fl_gnt_o             [NUM_PORTS-1:0],
  output logic [ADDR_W-1:0]     fl_block_idx_o,
  output logic                  fl_alloc_req_o,
  input  logic                  fl_alloc_gnt_i,
  input  logic [ADDR_W-1:0]     fl_alloc_block_idx_i,
  // learn table
  input  logic                  lt_eop_i             [NUM_PORTS-1:0],
  input  logic [47:0]           lt_src_i             [NUM_PORTS-1:0],
  input  logic [47:0]           lt_dst_i             [NUM_PORTS-1:0],
  input  logic [ADDR_W-1:0]     lt_start_i           [NUM_PORTS-1:0],
  output logic                  lt_valid_o,
  output logic [PW-1:0]         lt_port_o,
  output logic [47:0]           lt_src_o,
  output logic [47:0]           lt_dst_o,
  output logic [ADDR_W-1:0]     lt_start_o,
  output logic                  lt_drop_o            [NUM_PORTS-1:0]
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  // Returns {found, winner}: first requester scanning last+1, last+2, ... modulo NUM_PORTS.
  function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                          input logic [PW-1:0]        last);
    logic          found;
    logic [PW-1:0] win;
    logic [PW-1:0] pidx;
    int            idx;
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx  = (int'(last) + i) % NUM_PORTS;
      pidx = PW'(idx);
      if (!found && req[pidx]) begin
        found = 1'b1;
        win   = pidx;
      end
    end
    return {found, win};
  endfunction

  // ---------------------------------------------------------------- write arbiter
  logic [NUM_PORTS-1:0] w_wr_req;
  logic [PW:0]          w_wr_pick;
  logic                 w_wr_hold;
  logic                 w_wr_any;
  logic [PW-1:0]        w_wr_win;
  logic [PW-1:0]        r_wr_last;
  logic [BW-1:0]        r_burst_cnt;
  logic                 r_wr_active;

  // A burst only continues from a port that was actually granted last cycle.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) w_wr_req[p] = wr_req_i[p];
    w_wr_pick = rr_pick(w_wr_req, r_wr_last);
    w_wr_hold = r_wr_active && w_wr_req[r_wr_last] && (r_burst_cnt < BW'(MAX_BURST - 1));
    w_wr_any  = w_wr_hold || w_wr_pick[PW];
    w_wr_win  = w_wr_hold ? r_wr_last : w_wr_pick[PW-1:0];
  end

  always_comb begin
    mem_we_o    = w_wr_any;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) wr_gnt_o[p] = w_wr_any && (w_wr_win == PW'(p));
    if (w_wr_any) begin
      mem_addr_o  = wr_addr_i[w_wr_win];
      mem_wdata_o = wr_data_i[w_wr_win];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_last   <= PW'(NUM_PORTS - 1);
      r_burst_cnt <= '0;
      r_wr_active <= 1'b0;
    end else begin
      r_wr_active <= w_wr_any;
      if (w_wr_any) begin
        r_wr_last   <= w_wr_win;
        r_burst_cnt <= w_wr_hold ? r_burst_cnt + BW'(1) : '0;
      end
    end
  end

  // ---------------------------------------------------------------- free-list FSM
  typedef enum logic [0:0] {FL_IDLE = 1'b0, FL_REQ = 1'b1} fl_state_t;

  fl_state_t            r_fl_state;
  fl_state_t            w_fl_state_nxt;
  logic [NUM_PORTS-1:0] w_fl_req;
  logic [PW:0]          w_fl_pick;
  logic                 w_fl_done;
  logic [PW-1:0]        r_fl_owner;
  logic [PW-1:0]        r_fl_last;

  always_comb begin
    w_fl_state_nxt = r_fl_state;
    fl_alloc_req_o = 1'b0;
    fl_block_idx_o = '0;
    w_fl_done      = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) w_fl_req[p] = fl_req_i[p];
    w_fl_pick = rr_pick(w_fl_req, r_fl_last);
    case (r_fl_state)
      FL_IDLE: begin
        if (w_fl_pick[PW]) w_fl_state_nxt = FL_REQ;
      end
      FL_REQ: begin
        fl_alloc_req_o = 1'b1;
        if (fl_alloc_gnt_i) begin
          w_fl_done      = 1'b1;
          fl_block_idx_o = fl_alloc_block_idx_i;
          w_fl_state_nxt = FL_IDLE;
        end
      end
      default: w_fl_state_nxt = FL_IDLE;
    endcase
    for (int p = 0; p < NUM_PORTS; p++) fl_gnt_o[p] = w_fl_done && (r_fl_owner == PW'(p));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fl_state <= FL_IDLE;
      r_fl_owner <= '0;
      r_fl_last  <= PW'(NUM_PORTS - 1);
    end else begin
      r_fl_state <= w_fl_state_nxt;
      if (r_fl_state == FL_IDLE && w_fl_pick[PW]) begin
        r_fl_owner <= w_fl_pick[PW-1:0];
        r_fl_last  <= w_fl_pick[PW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------- learn channel
  logic [NUM_PORTS-1:0] r_pending;
  logic [NUM_PORTS-1:0] r_lt_drop;
  logic [47:0]          r_lt_src   [NUM_PORTS-1:0];
  logic [47:0]          r_lt_dst   [NUM_PORTS-1:0];
  logic [ADDR_W-1:0]    r_lt_start [NUM_PORTS-1:0];
  logic [PW-1:0]        r_lt_last;
  logic [PW:0]          w_lt_pick;
  logic                 w_lt_drain;
  logic [PW-1:0]        w_lt_win;
  logic [NUM_PORTS-1:0] w_lt_clr;

  always_comb begin
    w_lt_pick  = rr_pick(r_pending, r_lt_last);
    w_lt_drain = w_lt_pick[PW];
    w_lt_win   = w_lt_pick[PW-1:0];
    w_lt_clr   = '0;
    if (w_lt_drain) w_lt_clr[w_lt_win] = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) lt_drop_o[p] = r_lt_drop[p];
  end

  // A port being drained this cycle frees its buffer for a same-cycle capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_lt_drop  <= '0;
      r_lt_last  <= PW'(NUM_PORTS - 1);
      lt_valid_o <= 1'b0;
      lt_port_o  <= '0;
      lt_src_o   <= '0;
      lt_dst_o   <= '0;
      lt_start_o <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_lt_src[p]   <= '0;
        r_lt_dst[p]   <= '0;
        r_lt_start[p] <= '0;
      end
    end else begin
      lt_valid_o <= w_lt_drain;
      if (w_lt_drain) begin
        r_lt_last  <= w_lt_win;
        lt_port_o  <= w_lt_win;
        lt_src_o   <= r_lt_src[w_lt_win];
        lt_dst_o   <= r_lt_dst[w_lt_win];
        lt_start_o <= r_lt_start[w_lt_win];
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (lt_eop_i[p] && (!r_pending[p] || w_lt_clr[p])) begin
          r_pending[p]  <= 1'b1;
          r_lt_src[p]   <= lt_src_i[p];
          r_lt_dst[p]   <= lt_dst_i[p];
          r_lt_start[p] <= lt_start_i[p];
        end else begin
          if (w_lt_clr[p]) r_pending[p] <= 1'b0;
          if (lt_eop_i[p]) r_lt_drop[p] <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/rr_switch_arbiter.md
# rr_switch_arbiter

Work-conserving, parametrised round-robin arbiter for the switch's shared resources. It arbitrates three things between the RX ports:
- the single packet-memory write port, with optional burst hold;
- the free-list allocator, through a handshaked, one-outstanding FSM;
- the address-learn table, with a one-deep per-port capture buffer and drop flagging.

It sits between the per-port memory write controllers / RX MAC control and the shared memory, free list and learn table. Idle ports consume no slots.

## Interface
Parameters:
- NUM_PORTS, 4: number of RX ports, ≥2.
- ADDR_W, 12: block address width.
- BLOCK_BITS, 64: memory data width.
- MAX_BURST, 1: maximum consecutive write grants to one port; 1 gives pure round-robin.
- PW: localparam, $clog2(NUM_PORTS).

Ports (all per-port buses are unpacked [NUM_PORTS-1:0]):

Clock and reset:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.

Memory write port:
- wr_req_i  in  1/port  write request.
- wr_addr_i  in  ADDR_W/port  write address.
- wr_data_i  in  BLOCK_BITS/port  write data.
- wr_gnt_o  out  1/port  one-hot write grant.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory write address.
- mem_wdata_o  out  BLOCK_BITS  memory write data.

Free-list allocation:
- fl_req_i  in  1/port  allocation request.
- fl_gnt_o  out  1/port  allocation grant pulse.
- fl_block_idx_o  out  ADDR_W  allocated block index; shared bus, valid with fl_gnt_o.
- fl_alloc_req_o  out  1  request to the free list.
- fl_alloc_gnt_i  in  1  grant from the free list.
- fl_alloc_block_idx_i  in  ADDR_W  block index from the free list.

Learn table:
- lt_eop_i  in  1/port  end-of-packet pulse.
- lt_src_i  in  48/port  source MAC.
- lt_dst_i  in  48/port  destination MAC.
- lt_start_i  in  ADDR_W/port  packet start address.
- lt_valid_o  out  1  learn record valid.
- lt_port_o  out  PW  originating port.
- lt_src_o  out  48  source MAC.
- lt_dst_o  out  48  destination MAC.
- lt_start_o  out  ADDR_W  packet start address.
- lt_drop_o  out  1/port  sticky per-port drop flag.

## Operation
Round-robin rule (shared by all three arbiters):
- Each arbiter has its own last-winner register `last`, reset to NUM_PORTS-1, so port 0 wins first.
- The winner is the first requesting port scanning last+1, last+2, …, wrapping modulo NUM_PORTS.

Write arbiter (combinational grant):
- wr_gnt_o = one-hot winner, or all zero when no port requests.
- mem_we_o = |wr_gnt_o.
- mem_addr_o and mem_wdata_o are muxed from the winner; they are zero when there is no winner.
- A write commits in the cycle its grant is high.
- Burst hold: if port `last` still requests and burst_cnt < MAX_BURST-1, `last` wins again and burst_cnt increments.
- Otherwise normal round-robin applies and burst_cnt resets to 0 on the new winner.
- `last` updates only on cycles with a grant.

Free-list FSM (states IDLE, REQ):
- IDLE: if any fl_req_i is set, latch the round-robin winner into owner, update `last`, and go to REQ. fl_alloc_req_o = 0.
- REQ: fl_alloc_req_o = 1, held until fl_alloc_gnt_i.
- In the cycle fl_alloc_gnt_i = 1: fl_gnt_o[owner] = 1, fl_block_idx_o = fl_alloc_block_idx_i (combinational pass-through), and the FSM returns to IDLE.
- Requesters hold fl_req_i until their fl_gnt_o. If an owner drops its request in REQ, the FSM still completes and still pulses the grant.
- Free list empty (no grant): the FSM stays in REQ indefinitely and no other port is served.
- fl_gnt_o is all zero outside the completion cycle.

Learn channel:
- Each port has a pending bit and a field register (src, dst, start).
- On lt_eop_i[p]: if pending[p] = 0, or port p is drained in the same cycle, capture the fields and set pending.
- Otherwise discard the new record, keep the old one, and set lt_drop_o[p]. The drop flag clears only on reset.
- Each cycle the round-robin winner among pending ports is drained: its pending bit clears and the record is registered onto the lt_* outputs with lt_valid_o = 1 for one cycle.
- The learn table always accepts; there is no backpressure.

## Timing
Reset values:
- All `last` registers = NUM_PORTS-1.
- burst_cnt = 0.
- FSM = IDLE.
- pending, lt_drop_o, lt_valid_o and all lt_* data outputs = 0.
- Combinational outputs are 0 with inputs idle.

Latencies:
- Write grant: same cycle as request.
- Free-list request: fl_req_i sampled at edge t gives fl_alloc_req_o high from cycle t+1.
- Free-list grant: fl_gnt_o is in the same cycle as fl_alloc_gnt_i.
- Minimum spacing between two allocations is 2 cycles.
- Learn record: eop sampled at edge t gives pending at t+1 and lt_valid_o at t+2. The learn channel drains at most one record per cycle.

Reset mid-operation:
- An asynchronous reset mid-REQ returns the FSM to IDLE and drops the outstanding allocation.
- Reset clears all pending records without asserting lt_valid_o.

## Test plan
- All four wr_req_i held, MAX_BURST=1 → grants 0,1,2,3,0,… one per cycle; mem_addr_o tracks the winner.
- Only ports 1 and 3 request, MAX_BURST=3 → grants 1,1,1,3,3,3,1,…; idle ports never granted.
- fl_req_i on ports 0 and 2, free list grants after 3 cycles with idx 0x05, then 0x06 → fl_gnt_o[0] with 0x05, then fl_gnt_o[2] with 0x06; fl_alloc_req_o low for exactly one cycle between the two allocations.
- fl_alloc_gnt_i held low for 20 cycles → fl_alloc_req_o stays high, no fl_gnt_o; reset asserted → FSM back in IDLE, fl_alloc_req_o = 0.
- lt_eop_i on all ports in one cycle → four records on ports 0,1,2,3 in consecutive cycles starting t+2; lt_drop_o all 0.
- Port 3 eop in two consecutive cycles while ports 0–2 are also pending → second record dropped, lt_drop_o[3] = 1 and sticky; first record from port 3 delivered intact.
